// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder with a fixed, parameterised request-to-response
// latency. It accepts one load/store at a time, commits it to an internal
// word memory LATENCY rising edges after acceptance (counting the acceptance
// edge), presents the response until the initiator consumes it, and emits a
// one-cycle write event for every store that actually changes memory.
//
// Parameters
//   ADDR_W   word-address width; valid byte range is 0 .. 4*2^ADDR_W-1
//   LATENCY  rising edges from acceptance to response (1..4)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   req_valid      initiator presents a request
//   req_ready      responder is idle and can accept a request
//   req_we         1 = store, 0 = load
//   req_addr       byte address
//   req_wdata      store data
//   req_be         byte enables, bit i selects bits [8i+7:8i]
//   req_pc         PC of the issuing instruction (reported on the write event)
//   resp_valid     response available
//   resp_ready     initiator consumes the response
//   resp_rdata     load data; 0 for stores and errors
//   resp_err       request was misaligned or out of range
//   wr_evt_valid   one-cycle pulse when a store commits
//   wr_evt_pc      PC of the committed store
//   wr_evt_addr    word-aligned byte address of the committed store
//   wr_evt_data    full merged word after the commit
// -----------------------------------------------------------------------------
module dm_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        wr_evt_valid,
  output logic [31:0] wr_evt_pc,
  output logic [31:0] wr_evt_addr,
  output logic [31:0] wr_evt_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Count of extra WAIT edges after the acceptance edge, minus one.
  localparam logic [1:0] CNT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;

  // Request captured at the acceptance edge.
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_pc;

  logic [31:0] r_mem [DEPTH];

  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_wr_evt_valid;
  logic [31:0] r_wr_evt_pc;
  logic [31:0] r_wr_evt_addr;
  logic [31:0] r_wr_evt_data;

  logic              w_accept;
  logic              w_commit;
  logic              w_c_we;
  logic [31:0]       w_c_addr;
  logic [31:0]       w_c_wdata;
  logic [3:0]        w_c_be;
  logic [31:0]       w_c_pc;
  logic              w_c_err;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_old_word;
  logic [31:0]       w_merged;
  logic              w_do_write;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // The commit edge is the edge that enters RESP. With LATENCY=1 that is the
  // acceptance edge itself, so the live request inputs must be used there;
  // otherwise the latched copy is used (inputs are don't-care after accept).
  assign w_commit = ((r_state == S_WAIT) && (r_cnt == 2'd0)) ||
                    (w_accept && (LATENCY == 1));

  assign w_c_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_c_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_c_pc    = (r_state == S_IDLE) ? req_pc    : r_pc;

  assign w_c_err    = (|w_c_addr[1:0]) || (|w_c_addr[31:ADDR_W+2]);
  assign w_idx      = w_c_addr[ADDR_W+1:2];
  assign w_old_word = r_mem[w_idx];

  // Byte-lane merge of the store data into the current memory word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = w_c_be[gi] ? w_c_wdata[8*gi +: 8]
                                              : w_old_word[8*gi +: 8];
    end
  endgenerate

  // Only in-range, aligned stores with at least one enabled byte touch memory.
  assign w_do_write = w_commit && w_c_we && !w_c_err && (|w_c_be);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_pc    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
      r_pc    <= req_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Response and write-event registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_err     <= 1'b0;
      r_resp_rdata   <= '0;
      r_wr_evt_valid <= 1'b0;
      r_wr_evt_pc    <= '0;
      r_wr_evt_addr  <= '0;
      r_wr_evt_data  <= '0;
    end else begin
      r_wr_evt_valid <= w_do_write;
      if (w_commit) begin
        r_resp_err   <= w_c_err;
        r_resp_rdata <= (!w_c_we && !w_c_err) ? w_old_word : 32'd0;
      end else if ((r_state == S_RESP) && resp_ready) begin
        // Leave nothing stale on the bus once the response is consumed.
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
      if (w_do_write) begin
        r_wr_evt_pc   <= w_c_pc;
        r_wr_evt_addr <= {w_c_addr[31:2], 2'b00};
        r_wr_evt_data <= w_merged;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word memory (cleared on reset, so it is built from registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_write) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign wr_evt_valid = r_wr_evt_valid;
  assign wr_evt_pc    = r_wr_evt_pc;
  assign wr_evt_addr  = r_wr_evt_addr;
  assign wr_evt_data  = r_wr_evt_data;

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//
// Directed bench for dm_responder. Four instances (LATENCY = 1..4) share one
// set of request/response inputs; each directed step looks at the instance it
// is about. Index d of the per-instance arrays holds the LATENCY=d+1 copy.
// -----------------------------------------------------------------------------
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        resp_ready;

  logic        req_ready_a    [4];
  logic        resp_valid_a   [4];
  logic [31:0] resp_rdata_a   [4];
  logic        resp_err_a     [4];
  logic        wr_evt_valid_a [4];
  logic [31:0] wr_evt_pc_a    [4];
  logic [31:0] wr_evt_addr_a  [4];
  logic [31:0] wr_evt_data_a  [4];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      dm_responder #(
        .ADDR_W  (12),
        .LATENCY (gi + 1)
      ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready_a[gi]),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid_a[gi]),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata_a[gi]),
        .resp_err     (resp_err_a[gi]),
        .wr_evt_valid (wr_evt_valid_a[gi]),
        .wr_evt_pc    (wr_evt_pc_a[gi]),
        .wr_evt_addr  (wr_evt_addr_a[gi]),
        .wr_evt_data  (wr_evt_data_a[gi])
      );
    end
  endgenerate

  int n_pass  = 0;
  int n_total = 0;

  // Results of the most recent run_txn.
  int          t_lat;
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_evt_cnt;
  int          t_evt_at;
  logic [31:0] t_evt_pc;
  logic [31:0] t_evt_addr;
  logic [31:0] t_evt_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    req_pc    = $urandom;
  endtask

  // Issue one request to instance d with resp_ready held high, follow it to
  // its response and consume it. Inputs are scrambled after acceptance.
  task automatic run_txn(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] pc);
    int guard;
    guard = 0;
    resp_ready = 1'b1;
    while (!req_ready_a[d] && guard < 20) begin
      step();
      guard++;
    end
    check("ready_wait_timeout", 32'(guard >= 20), 32'd0);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_pc    = pc;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    scramble();
    t_lat     = 1;
    t_evt_cnt = 0;
    t_evt_at  = 0;
    while (1) begin
      if (wr_evt_valid_a[d]) begin
        t_evt_cnt++;
        t_evt_at   = t_lat;
        t_evt_pc   = wr_evt_pc_a[d];
        t_evt_addr = wr_evt_addr_a[d];
        t_evt_data = wr_evt_data_a[d];
      end
      if (resp_valid_a[d] || t_lat >= 20) break;
      step();
      t_lat++;
    end
    check("latency", 32'(t_lat), 32'(d + 1));
    t_rdata = resp_rdata_a[d];
    t_err   = resp_err_a[d];
    step();
    if (wr_evt_valid_a[d]) t_evt_cnt++;
    check("ready_after_handshake", 32'(req_ready_a[d]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first [4];
    int guard;
    logic [31:0] held;
    int seen;

    reset      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    scramble();
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("rst_req_ready",    32'(req_ready_a[1]),    32'd1);
    check("rst_resp_valid",   32'(resp_valid_a[1]),   32'd0);
    check("rst_resp_err",     32'(resp_err_a[1]),     32'd0);
    check("rst_resp_rdata",   resp_rdata_a[1],        32'd0);
    check("rst_wr_evt_valid", 32'(wr_evt_valid_a[1]), 32'd0);
    check("rst_wr_evt_pc",    wr_evt_pc_a[1],         32'd0);
    check("rst_wr_evt_addr",  wr_evt_addr_a[1],       32'd0);
    check("rst_wr_evt_data",  wr_evt_data_a[1],       32'd0);

    // Store then load, LATENCY=2.
    run_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h3000);
    $display("store 0x10 <= 0xDEADBEEF: lat=%0d err=%0d evt=%0d", t_lat, t_err, t_evt_cnt);
    check("st_evt_count", 32'(t_evt_cnt), 32'd1);
    check("st_evt_cycle", 32'(t_evt_at),  32'd2);
    check("st_evt_pc",    t_evt_pc,       32'h3000);
    check("st_evt_addr",  t_evt_addr,     32'h10);
    check("st_evt_data",  t_evt_data,     32'hDEADBEEF);
    check("st_err",       32'(t_err),     32'd0);
    check("st_rdata",     t_rdata,        32'd0);

    run_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h3004);
    $display("load 0x10 => 0x%08h err=%0d", t_rdata, t_err);
    check("ld10_rdata",  t_rdata,         32'hDEADBEEF);
    check("ld10_err",    32'(t_err),      32'd0);
    check("ld10_no_evt", 32'(t_evt_cnt),  32'd0);

    // Byte merge.
    run_txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h3008);
    $display("store 0x20 <= 0x11223344 be=F: evt_data=0x%08h", t_evt_data);
    check("mrg1_evt_data", t_evt_data, 32'h11223344);
    run_txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h300C);
    $display("store 0x20 <= 0xAABBCCDD be=5: evt_data=0x%08h", t_evt_data);
    check("mrg2_evt_count", 32'(t_evt_cnt), 32'd1);
    check("mrg2_evt_addr",  t_evt_addr,     32'h20);
    check("mrg2_evt_pc",    t_evt_pc,       32'h300C);
    check("mrg2_evt_data",  t_evt_data,     32'h11BB33DD);
    run_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h3010);
    $display("load 0x20 => 0x%08h err=%0d", t_rdata, t_err);
    check("mrg_ld_rdata", t_rdata, 32'h11BB33DD);

    // Errors.
    run_txn(1, 1'b0, 32'h22, 32'h0, 4'h0, 32'h3014);
    $display("load 0x22 => 0x%08h err=%0d", t_rdata, t_err);
    check("mis_ld_err",   32'(t_err), 32'd1);
    check("mis_ld_rdata", t_rdata,    32'd0);
    run_txn(1, 1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h3018);
    $display("store 0x4000 <= 0xCAFEF00D: err=%0d evt=%0d", t_err, t_evt_cnt);
    check("oor_st_err",    32'(t_err),     32'd1);
    check("oor_st_no_evt", 32'(t_evt_cnt), 32'd0);
    check("oor_st_rdata",  t_rdata,        32'd0);
    run_txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h301C);
    $display("load 0x0 => 0x%08h err=%0d", t_rdata, t_err);
    check("ld0_rdata", t_rdata,    32'd0);
    check("ld0_err",   32'(t_err), 32'd0);
    run_txn(1, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h3020);
    $display("store 0x12 <= 0xFFFFFFFF: err=%0d evt=%0d", t_err, t_evt_cnt);
    check("mis_st_err",    32'(t_err),     32'd1);
    check("mis_st_no_evt", 32'(t_evt_cnt), 32'd0);

    // Store with no byte enables.
    run_txn(1, 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h3024);
    $display("store 0x10 be=0: err=%0d evt=%0d", t_err, t_evt_cnt);
    check("be0_err",    32'(t_err),     32'd0);
    check("be0_no_evt", 32'(t_evt_cnt), 32'd0);
    run_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h3028);
    $display("load 0x10 => 0x%08h err=%0d", t_rdata, t_err);
    check("be0_ld_rdata", t_rdata, 32'hDEADBEEF);

    // Backpressure on the LATENCY=2 instance.
    resp_ready = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h20;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    scramble();
    guard = 0;
    while (!resp_valid_a[1] && guard < 20) begin
      step();
      guard++;
    end
    check("bp_resp_timeout", 32'(guard >= 20), 32'd0);
    held = resp_rdata_a[1];
    check("bp_rdata_first", held, 32'h11BB33DD);
    for (int i = 0; i < 5; i++) begin
      $display("backpressure cycle %0d: valid=%0d rdata=0x%08h ready=%0d",
               i + 1, resp_valid_a[1], resp_rdata_a[1], req_ready_a[1]);
      check("bp_valid_hold", 32'(resp_valid_a[1]), 32'd1);
      check("bp_rdata_hold", resp_rdata_a[1],      32'h11BB33DD);
      check("bp_req_ready",  32'(req_ready_a[1]),  32'd0);
      step();
    end
    resp_ready = 1'b1;
    check("bp_hs_valid",     32'(resp_valid_a[1]), 32'd1);
    check("bp_hs_req_ready", 32'(req_ready_a[1]),  32'd0);
    step();
    $display("after handshake: ready=%0d valid=%0d", req_ready_a[1], resp_valid_a[1]);
    check("bp_after_ready", 32'(req_ready_a[1]),  32'd1);
    check("bp_after_valid", 32'(resp_valid_a[1]), 32'd0);

    // Reset mid-WAIT on the LATENCY=4 instance.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    resp_ready = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h8;
    req_wdata  = 32'h5;
    req_be     = 4'hF;
    req_pc     = 32'h40;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    scramble();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("after mid-WAIT reset: ready=%0d valid=%0d evt=%0d",
             req_ready_a[3], resp_valid_a[3], wr_evt_valid_a[3]);
    check("mw_req_ready", 32'(req_ready_a[3]),    32'd1);
    check("mw_valid",     32'(resp_valid_a[3]),   32'd0);
    check("mw_rdata",     resp_rdata_a[3],        32'd0);
    check("mw_err",       32'(resp_err_a[3]),     32'd0);
    check("mw_evt_valid", 32'(wr_evt_valid_a[3]), 32'd0);
    check("mw_evt_data",  wr_evt_data_a[3],       32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid_a[3] || wr_evt_valid_a[3]) seen++;
      step();
    end
    check("mw_no_activity", 32'(seen), 32'd0);
    run_txn(3, 1'b0, 32'h8, 32'h0, 4'h0, 32'h44);
    $display("load 0x8 after reset => 0x%08h err=%0d", t_rdata, t_err);
    check("mw_ld_rdata", t_rdata, 32'd0);

    // Latency sweep across all four instances.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    resp_ready = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h4;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    scramble();
    for (int d = 0; d < 4; d++) first[d] = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      for (int d = 0; d < 4; d++) begin
        if (resp_valid_a[d] && first[d] == 0) first[d] = cyc;
      end
      if (cyc < 6) step();
    end
    for (int d = 0; d < 4; d++) begin
      $display("sweep LATENCY=%0d: first resp_valid after edge N+%0d", d + 1, first[d] - 1);
      check("sweep_latency", 32'(first[d]), 32'(d + 1));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
